spram_arb: RTL
==============

SPRAM_ARB -- requirements
Module: spram_arb

Interface
REQ-001 SHALL have parameter AW, default 14, SPRAM word-address width.
REQ-002 SHALL have parameter DW, default 16, SPRAM data width.
REQ-003 SHALL have ports clk (in, 1, sole clock) and rst_n (in, 1, asynchronous active-low reset), listed first.
REQ-004 SHALL have a_req_valid (in, 1), a_req_ready (out, 1), a_req_we (in, 1), a_req_addr (in, AW) and a_req_wdata (in, DW), forming the port A request.
REQ-005 SHALL have a_rsp_valid (out, 1) and a_rsp_rdata (out, DW), forming the port A read response.
REQ-006 SHALL have b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wdata, b_rsp_valid and b_rsp_rdata, identical to port A, forming port B.
REQ-007 SHALL have mem_cs (out, 1), mem_wren (out, 1), mem_addr (out, AW), mem_din (out, DW) and mem_dout (in, DW), forming the SPRAM side; read data is registered inside the SPRAM.
REQ-008 SHALL have cnt_a, cnt_b and cnt_conflict (out, 16 each), the statistics counters.

Function
REQ-009 SHALL grant at most one request per cycle; x_req_ready is combinational and equals that port's grant.
REQ-010 SHALL grant the only requester when exactly one x_req_valid is high, regardless of the priority pointer.
REQ-011 SHALL resolve simultaneous requests round-robin: the 1-bit pointer names the preferred port and flips to the other port after every contested grant.
REQ-012 SHALL leave the pointer unchanged on uncontested grants and idle cycles.
REQ-013 SHALL drive the SPRAM combinationally on a grant: mem_cs=1, mem_wren=req_we, mem_addr=req_addr, mem_din=req_wdata.
REQ-014 SHALL drive mem_cs=0, mem_wren=0, mem_addr=0 and mem_din=0 when no grant is made.
REQ-015 SHALL register a read-pending flag and a port ID on each granted read (we=0).
REQ-016 SHALL pulse the owning port's x_rsp_valid for one cycle, exactly one cycle after the grant, with x_rsp_rdata=mem_dout.
REQ-017 SHALL hold the non-owning port's x_rsp_rdata at 0 and both x_rsp_valid low when no read is pending.
REQ-018 SHALL produce no response for writes.
REQ-019 SHALL sustain back-to-back reads at one per cycle, alternating ports under contention, with no bubbles.
REQ-020 SHALL, for a write then a read to the same address on consecutive cycles, return the newly written data, relying on SPRAM write-before-read ordering.

Reset
REQ-021 SHALL on rst_n low set the pointer to port A, clear the read-pending flag, and clear all counters, with all x_rsp_valid and mem_cs at 0.
REQ-022 SHALL drop a read in flight when reset asserts; no response is issued after reset release.
REQ-023 SHALL grant nothing while rst_n is low, with both x_req_ready at 0.

Configuration
REQ-024 SHALL, with SPRAM_ARB_STATS_EN defined, count grants to A (cnt_a), grants to B (cnt_b) and cycles with both valid (cnt_conflict), each 16-bit and saturating at 0xFFFF.
REQ-025 SHALL, without SPRAM_ARB_STATS_EN, tie all counter outputs to 0 and synthesize no counter flops.

Structure
REQ-026 SHALL place the port-ID encoding (PORT_A=0, PORT_B=1) and the default AW/DW constants in package spram_pkg.
REQ-027 SHALL implement the two-input round-robin grant logic as sub-module spram_rr_arb (inputs req[1:0] and pointer; output gnt[1:0]).
REQ-028 SHALL keep the SPRAM model or primitive outside this block; the block connects only to mem_* ports.

Verification
REQ-029 SHALL cover single read: A read at addr 0x0010 holding 0xBEEF -> a_req_ready same cycle, a_rsp_valid plus a_rsp_rdata=0xBEEF next cycle, b_rsp_valid stays 0.
REQ-030 SHALL cover contention: A and B both reading every cycle for 4 cycles after reset -> grants A,B,A,B, responses routed to the matching port one cycle later.
REQ-031 SHALL cover write then read: B writes 0x1234 to 0x3FFF, then A reads 0x3FFF next cycle -> a_rsp_rdata=0x1234 and no B response.
REQ-032 SHALL cover reset mid-read: A read granted, then rst_n low for the following cycle -> a_rsp_valid never asserts, and the pointer is A after release.
REQ-033 SHALL cover counter saturation: with SPRAM_ARB_STATS_EN, 70000 uncontested A grants -> cnt_a=0xFFFF, cnt_b=0, cnt_conflict=0; without the macro all counters read 0.

Source files
------------

// File: rtl/spram_pkg.sv
// Shared constants for the single-port RAM arbiter: port IDs, default sizes
// and a saturating increment used by the optional statistics counters.
package spram_pkg;

  localparam int AW_DEF = 14;
  localparam int DW_DEF = 16;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/spram_rr_arb.sv
// Two-input round-robin grant: a lone requester always wins, and on contention
// the port named by the pointer wins.
module spram_rr_arb
  import spram_pkg::*;
(
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] gnt
);

  // Grant decode; the pointer only matters when both ports request.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (pointer == PORT_A) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/spram_arb.sv
// Two-port front end sharing one single-port RAM with one-cycle read latency.
// Optional grant/conflict statistics are built when SPRAM_ARB_STATS_EN is defined.
module spram_arb
  import spram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req_valid,
  output logic          a_req_ready,
  input  logic          a_req_we,
  input  logic [AW-1:0] a_req_addr,
  input  logic [DW-1:0] a_req_wdata,
  output logic          a_rsp_valid,
  output logic [DW-1:0] a_rsp_rdata,
  input  logic          b_req_valid,
  output logic          b_req_ready,
  input  logic          b_req_we,
  input  logic [AW-1:0] b_req_addr,
  input  logic [DW-1:0] b_req_wdata,
  output logic          b_rsp_valid,
  output logic [DW-1:0] b_rsp_rdata,
  output logic          mem_cs,
  output logic          mem_wren,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic [15:0]   cnt_a,
  output logic [15:0]   cnt_b,
  output logic [15:0]   cnt_conflict
);

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_conflict;
  logic       w_rd_gnt;
  logic       r_ptr;
  logic       r_pend;
  logic       r_pid;

  // Requests are masked while in reset so nothing is granted or issued.
  assign w_req      = {b_req_valid, a_req_valid} & {2{rst_n}};
  assign w_conflict = (w_req == 2'b11);

  spram_rr_arb u_rr (
    .req     (w_req),
    .pointer (r_ptr),
    .gnt     (w_gnt)
  );

  assign a_req_ready = w_gnt[0];
  assign b_req_ready = w_gnt[1];
  assign w_rd_gnt    = (w_gnt[0] & ~a_req_we) | (w_gnt[1] & ~b_req_we);

  // RAM command mux: the granted port's request, all zeros when idle.
  always_comb begin
    mem_cs   = 1'b0;
    mem_wren = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (w_gnt[0]) begin
      mem_cs   = 1'b1;
      mem_wren = a_req_we;
      mem_addr = a_req_addr;
      mem_din  = a_req_wdata;
    end else if (w_gnt[1]) begin
      mem_cs   = 1'b1;
      mem_wren = b_req_we;
      mem_addr = b_req_addr;
      mem_din  = b_req_wdata;
    end else begin
      mem_cs   = 1'b0;
    end
  end

  // Priority pointer flips only after a contested grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= PORT_A;
    end else if (w_conflict) begin
      r_ptr <= ~r_ptr;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Read-pending tracker; the RAM returns data the cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_pid  <= PORT_A;
    end else begin
      r_pend <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_pid <= w_gnt[1];
      end else begin
        r_pid <= r_pid;
      end
    end
  end

  assign a_rsp_valid = r_pend & (r_pid == PORT_A);
  assign b_rsp_valid = r_pend & (r_pid == PORT_B);
  assign a_rsp_rdata = a_rsp_valid ? mem_dout : '0;
  assign b_rsp_rdata = b_rsp_valid ? mem_dout : '0;

`ifdef SPRAM_ARB_STATS_EN
  logic [15:0] r_cnt_a;
  logic [15:0] r_cnt_b;
  logic [15:0] r_cnt_conflict;

  // Saturating grant and contention statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_a        <= 16'h0000;
      r_cnt_b        <= 16'h0000;
      r_cnt_conflict <= 16'h0000;
    end else begin
      r_cnt_a        <= w_gnt[0]   ? sat_inc16(r_cnt_a)        : r_cnt_a;
      r_cnt_b        <= w_gnt[1]   ? sat_inc16(r_cnt_b)        : r_cnt_b;
      r_cnt_conflict <= w_conflict ? sat_inc16(r_cnt_conflict) : r_cnt_conflict;
    end
  end

  assign cnt_a        = r_cnt_a;
  assign cnt_b        = r_cnt_b;
  assign cnt_conflict = r_cnt_conflict;
`else
  assign cnt_a        = 16'h0000;
  assign cnt_b        = 16'h0000;
  assign cnt_conflict = 16'h0000;
`endif

endmodule
